// File: rtl/fpu_pkg.sv
// Shared types and constants for the bfloat16 FPU command dispatcher.
// Op indices equal the bit positions of the one-hot sfpu_op bus.
package fpu_pkg;

  localparam int BF16_W = 16;
  localparam int SFPU_W = 24;
  localparam int VFPU_W = 28;
  localparam int FLAG_W = 5;
  localparam int OP_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPT,
    ST_RESP
  } state_t;

  localparam int OP_FADD    = 0;
  localparam int OP_FSUB    = 1;
  localparam int OP_FMUL    = 2;
  localparam int OP_FDIV    = 3;
  localparam int OP_FSQRT   = 4;
  localparam int OP_FMIN    = 5;
  localparam int OP_FMAX    = 6;
  localparam int OP_FLT     = 7;
  localparam int OP_FMADD   = 8;
  localparam int OP_FEQ     = 9;
  localparam int OP_FLE     = 10;
  localparam int OP_FMV_X   = 11;
  localparam int OP_FSGNJ   = 12;
  localparam int OP_FSGNJN  = 13;
  localparam int OP_FCVT_W  = 14;
  localparam int OP_FCVT_PW = 15;
  localparam int OP_FSGNJX  = 16;
  localparam int OP_FMSUB   = 17;
  localparam int OP_FNMADD  = 18;
  localparam int OP_FNMSUB  = 19;
  localparam int OP_FMV_P   = 20;
  localparam int OP_FCLASS  = 21;
  localparam int OP_UNSIGN  = 22;
  localparam int OP_SIGN    = 23;
  localparam int OP_LAST    = OP_FCLASS;

  // Ops whose architectural result is the 32-bit integer bus
  localparam logic [SFPU_W-1:0] TO_INT_SET = 24'h204E80;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [FLAG_W-1:0] FLAGS_ILLEGAL = 5'b10000;

  function automatic logic is_fcvt(input logic [OP_W-1:0] op);
    return (op == 5'(OP_FCVT_W)) || (op == 5'(OP_FCVT_PW));
  endfunction

endpackage

// File: rtl/fpu_dispatch_decode.sv
// Combinational op decoder: op index to one-hot sfpu_op plus
// legality and integer-result classification.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic              uns,
  output logic [SFPU_W-1:0] onehot,
  output logic              legal,
  output logic              to_int
);

  always_comb begin
    onehot = '0;
    to_int = 1'b0;
    legal  = (op <= 5'(OP_LAST));
    if (legal) begin
      onehot[op] = 1'b1;
      to_int     = TO_INT_SET[op];
      if (is_fcvt(op)) begin
        if (uns) onehot[OP_UNSIGN] = 1'b1;
        else     onehot[OP_SIGN]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_dispatch.sv
// Single-outstanding command dispatcher between a host and a
// fixed-latency bfloat16 FPU, with sticky flag accumulation.
module fpu_dispatch
  import fpu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_unsigned,
  input  logic [2:0]        req_rm,
  input  logic [BF16_W-1:0] req_a,
  input  logic [BF16_W-1:0] req_b,
  input  logic [BF16_W-1:0] req_c,
  input  logic [31:0]       req_int,
  output logic [BF16_W-1:0] fpu_a,
  output logic [BF16_W-1:0] fpu_b,
  output logic [BF16_W-1:0] fpu_c,
  output logic [31:0]       fpu_int,
  output logic [2:0]        fpu_frm,
  output logic [SFPU_W-1:0] fpu_sfpu_op,
  output logic [VFPU_W-1:0] fpu_vfpu_op,
  output logic [2:0]        fpu_sel,
  input  logic [BF16_W-1:0] fpu_result,
  input  logic [31:0]       fpu_result_rd,
  input  logic [FLAG_W-1:0] fpu_flags,
  input  logic              fpu_exc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [FLAG_W-1:0] rsp_flags,
  output logic [FLAG_W-1:0] fflags,
  input  logic              fflags_clr,
  output logic              busy
);

  localparam logic [7:0] WAIT_INIT = 8'(LAT > 1 ? LAT - 2 : 0);

  state_t            state;
  logic [7:0]        cnt;
  logic              to_int_q;
  logic [SFPU_W-1:0] dec_oh;
  logic              dec_legal;
  logic              dec_to_int;
  logic [FLAG_W-1:0] fflags_base;

  fpu_op_decode u_dec (
    .op     (req_op),
    .uns    (req_unsigned),
    .onehot (dec_oh),
    .legal  (dec_legal),
    .to_int (dec_to_int)
  );

  assign req_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign fpu_vfpu_op = '0;
  assign fpu_sel     = '0;
  assign fflags_base = fflags_clr ? '0 : fflags;

  always_ff @(posedge clk) begin
    if (rst_l) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      to_int_q    <= 1'b0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_c       <= '0;
      fpu_int     <= '0;
      fpu_frm     <= '0;
      fpu_sfpu_op <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_flags   <= '0;
      fflags      <= '0;
    end else begin
      fpu_sfpu_op <= '0;
      fflags      <= fflags_base;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            fpu_a    <= req_a;
            fpu_b    <= req_b;
            fpu_c    <= req_c;
            fpu_int  <= req_int;
            fpu_frm  <= req_rm;
            to_int_q <= dec_to_int;
            if (dec_legal) begin
              fpu_sfpu_op <= dec_oh;
              state       <= ST_ISSUE;
            end else begin
              rsp_data  <= '0;
              rsp_flags <= FLAGS_ILLEGAL;
              rsp_valid <= 1'b1;
              fflags    <= fflags_base | FLAGS_ILLEGAL;
              state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          // LAT of 1 leaves no room for a WAIT cycle
          if (LAT < 2) begin
            state <= ST_CAPT;
          end else begin
            cnt   <= WAIT_INIT;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_CAPT;
          else           cnt   <= cnt - 8'd1;
        end
        ST_CAPT: begin
          if (to_int_q && !fpu_exc) rsp_data <= fpu_result_rd;
          else                      rsp_data <= {16'h0000, fpu_result};
          rsp_flags <= fpu_flags;
          rsp_valid <= 1'b1;
          fflags    <= fflags_base | fpu_flags;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpu_dispatch.md
FPU_DISPATCH -- requirements
Module: fpu_dispatch

Interface
REQ-001 Parameter LAT, default 2: FPU cycles from opcode presented to result readable (input register plus result register).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_l  input  1  synchronous, active-high reset (1 = reset).
REQ-004 req_valid  input  1  host command valid.
REQ-005 req_ready  output  1  dispatcher accepts a command this cycle.
REQ-006 req_op  input  5  encoded op index 0..21 = sfpu_op bit position; 22..31 illegal.
REQ-007 req_unsigned  input  1  for FCVT ops (14, 15): 1 selects sfpu bit 22, 0 selects bit 23.
REQ-008 req_rm  input  3  rounding mode.
REQ-009 req_a, req_b, req_c  input  16 each  bfloat16 operands.
REQ-010 req_int  input  32  integer operand for FCVT.P.W.
REQ-011 fpu_a, fpu_b, fpu_c  output  16 each  operands to FPU.
REQ-012 fpu_int  output  32;  fpu_frm  output  3;  fpu_sfpu_op  output  24 one-hot;  fpu_vfpu_op  output  28 (constant 0);  fpu_sel  output  3 (constant 0).
REQ-013 fpu_result  input  16;  fpu_result_rd  input  32;  fpu_flags  input  5 {NV,DZ,OF,UF,NX};  fpu_exc  input  1.
REQ-014 rsp_valid  output  1;  rsp_ready  input  1;  rsp_data  output  32;  rsp_flags  output  5.
REQ-015 fflags  output  5  sticky accumulated flags;  fflags_clr  input  1  clears fflags.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, CAPT, RESP; req_ready SHALL equal (state==IDLE).
REQ-018 IDLE: on req_valid, register operands, rm, op; legal op -> ISSUE; illegal op -> RESP with rsp_data=0, rsp_flags=5'b10000; no FPU issue.
REQ-019 ISSUE (exactly one cycle): fpu_sfpu_op has bit req_op set, plus bit 22/23 per req_unsigned when op is 14 or 15; all other states drive fpu_sfpu_op=0.
REQ-020 fpu_a/b/c/int/frm SHALL hold the registered command from ISSUE through CAPT; 0 in IDLE after reset.
REQ-021 WAIT lasts LAT-1 cycles via down-counter; then CAPT for one cycle; CAPT is cycle ISSUE+LAT.
REQ-022 CAPT end: rsp_data = fpu_result_rd if op in {7,9,10,11,14,21} and fpu_exc=0, else {16'h0000, fpu_result}; rsp_flags = fpu_flags; go to RESP.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_flags stable until rsp_valid & rsp_ready; then IDLE in the next cycle.
REQ-024 Accept-to-rsp_valid latency: LAT+2 cycles for legal ops (4 at default), 1 cycle for illegal ops.
REQ-025 fflags |= rsp_flags on the cycle the response is loaded (CAPT or illegal accept).
REQ-026 fflags_clr same cycle as a load: fflags = new rsp_flags only; clr alone: fflags = 0.
REQ-027 No new command accepted while busy; req_valid held by host is accepted the cycle after return to IDLE.

Reset
REQ-028 rst_l=1 at a clock edge: state=IDLE, counter=0, all outputs 0 except req_ready=1 after release; fflags=0.
REQ-029 Reset mid-operation discards the in-flight op; no response is ever produced for it; fpu_sfpu_op=0 from the next cycle.

Structure
REQ-030 Shared package fpu_pkg holds: state encoding, op index constants (FADD=0 .. FCLASS=21, UNSIGN=22, SIGN=23), to-int op set, flag bit positions, bf16 width 16.
REQ-031 One sub-module fpu_op_decode: combinational req_op/req_unsigned -> 24-bit one-hot, legal bit, to_int bit.
REQ-032 Target 150-300 lines RTL total.

Verification
REQ-033 FADD: a=0x3F80, b=0x4000 -> rsp_data=0x00004040, rsp_flags=0, rsp_valid 4 cycles after accept, fpu_sfpu_op=24'h000001 for exactly one cycle.
REQ-034 FMUL: a=0x4000, b=0x4040 -> rsp_data=0x000040C0; FEQ (op 9): a=b=0x3F80 -> rsp_data=0x00000001 from fpu_result_rd.
REQ-035 Illegal op 25 -> rsp_valid 1 cycle after accept, rsp_flags=5'b10000, fpu_sfpu_op stays 0, fflags=5'b10000.
REQ-036 Backpressure: rsp_ready low 3 cycles in RESP -> rsp_data/rsp_flags/rsp_valid unchanged; req_ready=0 throughout; one transfer on rsp_ready.
REQ-037 Reset asserted in WAIT -> next cycle IDLE, rsp_valid never rises, fflags=0; then FCVT.P.W unsigned req_int=3 -> fpu_sfpu_op=24'h408000, rsp_data=0x00004040.
REQ-038 fflags_clr coincident with an illegal-op load while fflags=5'b00001 -> fflags=5'b10000.
